bam_multi_channel: RTL

BAM_MULTI_CHANNEL -- requirements
Module: bam_multi_channel

---
 rtl/bam_pkg.sv | 24 ++
 rtl/bam_prescaler.sv | 29 ++
 rtl/bam_multi_channel.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bam_pkg.sv
// Shared definitions for the multi-channel BAM block: register offsets,
// CONFIG/STATUS bit positions, prescaler width and the run-state enum.
package bam_pkg;

    localparam int OFF_CONFIG  = 0;
    localparam int OFF_STATUS  = 1;
    localparam int OFF_DCYCLE  = 2;

    localparam int CFG_START_BIT = 0;
    localparam int CFG_PRESC_LSB = 1;
    localparam int PRESC_W       = 3;

    localparam int STAT_RUNNING_BIT    = 0;
    localparam int STAT_FRAME_SEEN_BIT = 1;

    // Wide enough to count up to 2^(2^PRESC_W - 1) clocks per tick.
    localparam int PRESC_CNT_W = 2 ** PRESC_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } bam_state_t;

endpackage

// File: rtl/bam_prescaler.sv
// Tick-enable generator: one tick every 2^i_presc clocks, held in reset
// while i_clear is high so a fresh run starts on a clean count.
module bam_prescaler
    import bam_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_CNT_W-1:0] r_count;
    logic [PRESC_CNT_W-1:0] w_limit;

    assign w_limit = (PRESC_CNT_W'(1) << i_presc) - PRESC_CNT_W'(1);
    assign o_tick  = (r_count == w_limit);

    always_ff @(posedge i_clk) begin
        if (i_arst || i_clear) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PRESC_CNT_W'(1);
        end
    end

endmodule

// File: rtl/bam_multi_channel.sv
// Multi-channel binary-angle-modulation generator with a small register file.
// Optional per-channel output inversion under BAM_MULTI_CHANNEL_POLARITY_EN.
module bam_multi_channel
    import bam_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int RES       = 16,
    parameter int BASE_ADDR = 128
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_we,
    input  logic [31:0]         i_address,
    input  logic [31:0]         i_write_data,
    output logic [31:0]         o_read_data,
    output logic [CHANNELS-1:0] bam_output,
    output logic                o_frame
);

    localparam int IDX_W = (RES > 1) ? $clog2(RES) : 1;
    localparam logic [31:0] A_CONFIG = 32'(BASE_ADDR + OFF_CONFIG);
    localparam logic [31:0] A_STATUS = 32'(BASE_ADDR + OFF_STATUS);

    bam_state_t r_state;
    bam_state_t w_state_next;

    logic                r_cfg_start;
    logic [PRESC_W-1:0]  r_pend_presc;
    logic [PRESC_W-1:0]  r_act_presc;
    logic [RES-1:0]      r_pend_dc [CHANNELS];
    logic [RES-1:0]      r_act_dc  [CHANNELS];
    logic [IDX_W-1:0]    r_idx;
    logic [RES-1:0]      r_slot;
    logic                r_frame_seen;
    logic [CHANNELS-1:0] w_polarity;
    logic [31:0]         w_read_data;

    logic w_cfg_wr;
    logic w_start;
    logic w_stop;
    logic w_tick;
    logic w_slot_last;
    logic w_idx_last;
    logic w_frame_end;
    logic w_unused_data;

    assign w_unused_data = ^i_write_data;

    assign w_cfg_wr = i_we && (i_address == A_CONFIG);
    assign w_start  = w_cfg_wr && i_write_data[CFG_START_BIT] && (r_state == ST_IDLE);
    assign w_stop   = w_cfg_wr && !i_write_data[CFG_START_BIT] && (r_state == ST_RUN);

    bam_prescaler u_prescaler (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_clear (r_state == ST_IDLE),
        .i_presc (r_act_presc),
        .o_tick  (w_tick)
    );

    // Slot k lasts 2^k ticks; the frame ends on the last tick of slot RES-1.
    assign w_slot_last = (r_slot == ((RES'(1) << r_idx) - RES'(1)));
    assign w_idx_last  = (r_idx == IDX_W'(RES - 1));
    assign w_frame_end = (r_state == ST_RUN) && !w_stop && w_tick && w_slot_last && w_idx_last;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_RUN;
            ST_RUN:  if (w_stop)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst || (r_state == ST_IDLE) || w_stop) begin
            r_idx  <= '0;
            r_slot <= '0;
        end else if (w_tick) begin
            if (w_slot_last) begin
                r_slot <= '0;
                r_idx  <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_slot <= r_slot + RES'(1);
            end
        end
    end

    // Active values only change at a run start or a frame boundary.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_act_presc <= '0;
            for (int n = 0; n < CHANNELS; n++) r_act_dc[n] <= '0;
        end else if (w_start) begin
            r_act_presc <= i_write_data[CFG_PRESC_LSB +: PRESC_W];
            for (int n = 0; n < CHANNELS; n++) r_act_dc[n] <= r_pend_dc[n];
        end else if (w_frame_end) begin
            r_act_presc <= r_pend_presc;
            for (int n = 0; n < CHANNELS; n++) r_act_dc[n] <= r_pend_dc[n];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_cfg_start  <= 1'b0;
            r_pend_presc <= '0;
            for (int n = 0; n < CHANNELS; n++) r_pend_dc[n] <= '0;
        end else if (i_we) begin
            if (i_address == A_CONFIG) begin
                r_cfg_start  <= i_write_data[CFG_START_BIT];
                r_pend_presc <= i_write_data[CFG_PRESC_LSB +: PRESC_W];
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (i_address == 32'(BASE_ADDR + OFF_DCYCLE + n)) begin
                    r_pend_dc[n] <= i_write_data[RES-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_frame_seen <= 1'b0;
        end else if (w_frame_end) begin
            r_frame_seen <= 1'b1;
        end else if (i_we && (i_address == A_STATUS)) begin
            r_frame_seen <= 1'b0;
        end
    end

`ifdef BAM_MULTI_CHANNEL_POLARITY_EN
    localparam logic [31:0] A_POLARITY = 32'(BASE_ADDR + OFF_DCYCLE + CHANNELS);
    logic [CHANNELS-1:0] r_polarity;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_polarity <= '0;
        end else if (i_we && (i_address == A_POLARITY)) begin
            r_polarity <= i_write_data[CHANNELS-1:0];
        end
    end

    assign w_polarity = r_polarity;
`else
    assign w_polarity = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_arst || w_stop || (r_state != ST_RUN)) begin
            bam_output <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                bam_output[n] <= r_act_dc[n][r_idx] ^ w_polarity[n];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_frame <= 1'b0;
        end else begin
            o_frame <= w_frame_end;
        end
    end

    always_comb begin
        w_read_data = '0;
        if (i_address == A_CONFIG) begin
            w_read_data[CFG_START_BIT]                = r_cfg_start;
            w_read_data[CFG_PRESC_LSB +: PRESC_W]     = r_pend_presc;
        end
        if (i_address == A_STATUS) begin
            w_read_data[STAT_RUNNING_BIT]    = (r_state == ST_RUN);
            w_read_data[STAT_FRAME_SEEN_BIT] = r_frame_seen;
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (i_address == 32'(BASE_ADDR + OFF_DCYCLE + n)) begin
                w_read_data[RES-1:0] = r_pend_dc[n];
            end
        end
`ifdef BAM_MULTI_CHANNEL_POLARITY_EN
        if (i_address == A_POLARITY) begin
            w_read_data[CHANNELS-1:0] = r_polarity;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_read_data <= '0;
        end else begin
            o_read_data <= w_read_data;
        end
    end

endmodule
